// File: rtl/audio_front_end.sv
// Microphone front end: DC-offset calibration, saturating offset removal and
// accumulate-and-dump decimation, all in the audio_clk domain.
module audio_front_end #(
   parameter int WIDTH        = 16,
   parameter int CAL_LOG2     = 10,
   parameter int DECIM_LOG2   = 1,
   parameter int FIXED_OFFSET = -2000
) (
   input  logic             audio_clk,
   input  logic             rst_in_n,
   input  logic             sample_valid_in,
   input  logic [WIDTH-1:0] sample_in,
   input  logic             cal_start_in,
   input  logic [1:0]       offset_mode_in,
   output logic             calibrating_out,
   output logic             offset_valid_out,
   output logic [WIDTH-1:0] offset_out,
   output logic [WIDTH-1:0] dc_blocked_out,
   output logic             sample_valid_out,
   output logic [WIDTH-1:0] sample_out
);

   localparam logic [WIDTH-1:0] FIXED_W = FIXED_OFFSET[WIDTH-1:0];
   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CAL, DONE} state_t;

   state_t state_reg, state_next;
   logic cal_clear, cal_add, cal_finish;

   logic [WIDTH-1:0]          raw_q;
   logic                      v1, v2;
   logic [WIDTH-1:0]          off_sel;
   logic [WIDTH:0]            diff;
   logic [WIDTH-1:0]          dc_next;
   logic [CAL_LOG2-1:0]       cal_cnt;
   logic [WIDTH+CAL_LOG2-1:0] cal_acc, cal_sum;

   // S1: capture raw sample
   always_ff @(posedge audio_clk or negedge rst_in_n) begin
      if (!rst_in_n) begin
         raw_q <= '0;
         v1    <= 1'b0;
      end else begin
         v1 <= sample_valid_in;
         if (sample_valid_in) raw_q <= sample_in;
      end
   end

   always_comb begin
      off_sel = '0;
      case (offset_mode_in)
         2'd0: off_sel = '0;
         2'd1: off_sel = FIXED_W;
         2'd2: off_sel = offset_valid_out ? offset_out : '0;
         2'd3: off_sel = offset_valid_out ? offset_out : FIXED_W;
         default: off_sel = '0;
      endcase
   end

   // Difference carried one bit wider so overflow shows as a sign disagreement.
   assign diff    = {raw_q[WIDTH-1], raw_q} - {off_sel[WIDTH-1], off_sel};
   assign dc_next = (diff[WIDTH] != diff[WIDTH-1]) ?
                    (diff[WIDTH] ? MAX_NEG : MAX_POS) : diff[WIDTH-1:0];

   // S2: DC-corrected sample
   always_ff @(posedge audio_clk or negedge rst_in_n) begin
      if (!rst_in_n) begin
         dc_blocked_out <= '0;
         v2             <= 1'b0;
      end else begin
         v2 <= v1;
         if (v1) dc_blocked_out <= dc_next;
      end
   end

   // S3: accumulate-and-dump decimator
   generate
      if (DECIM_LOG2 == 0) begin : g_nodecim
         always_ff @(posedge audio_clk or negedge rst_in_n) begin
            if (!rst_in_n) begin
               sample_out       <= '0;
               sample_valid_out <= 1'b0;
            end else begin
               sample_valid_out <= v2;
               if (v2) sample_out <= dc_blocked_out;
            end
         end
      end else begin : g_decim
         logic [DECIM_LOG2-1:0]       phase;
         logic [WIDTH+DECIM_LOG2-1:0] acc, acc_sum;

         assign acc_sum = acc + {{DECIM_LOG2{dc_blocked_out[WIDTH-1]}}, dc_blocked_out};

         always_ff @(posedge audio_clk or negedge rst_in_n) begin
            if (!rst_in_n) begin
               phase            <= '0;
               acc              <= '0;
               sample_out       <= '0;
               sample_valid_out <= 1'b0;
            end else begin
               sample_valid_out <= 1'b0;
               if (v2) begin
                  phase <= phase + 1'b1;
                  if (&phase) begin
                     // Top bits of the group sum are the floor of the mean.
                     sample_out       <= acc_sum[WIDTH+DECIM_LOG2-1:DECIM_LOG2];
                     sample_valid_out <= 1'b1;
                     acc              <= '0;
                  end else begin
                     acc <= acc_sum;
                  end
               end
            end
         end
      end
   endgenerate

   // Calibration FSM
   always_ff @(posedge audio_clk or negedge rst_in_n) begin
      if (!rst_in_n) state_reg <= IDLE;
      else           state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      cal_clear  = 1'b0;
      cal_add    = 1'b0;
      cal_finish = 1'b0;
      case (state_reg)
         IDLE, DONE: begin
            if (cal_start_in) begin
               state_next = CAL;
               cal_clear  = 1'b1;
            end
         end
         CAL: begin
            if (cal_start_in) begin
               cal_clear = 1'b1;
            end else if (v1) begin
               cal_add = 1'b1;
               if (&cal_cnt) begin
                  cal_finish = 1'b1;
                  state_next = DONE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign calibrating_out = (state_reg == CAL);
   assign cal_sum = cal_acc + {{CAL_LOG2{raw_q[WIDTH-1]}}, raw_q};

   always_ff @(posedge audio_clk or negedge rst_in_n) begin
      if (!rst_in_n) begin
         cal_acc          <= '0;
         cal_cnt          <= '0;
         offset_out       <= '0;
         offset_valid_out <= 1'b0;
      end else begin
         if (cal_clear) begin
            cal_acc <= '0;
            cal_cnt <= '0;
         end else if (cal_add) begin
            cal_acc <= cal_sum;
            cal_cnt <= cal_cnt + 1'b1;
         end
         // Old offset stays in use until the new one lands in this single edge.
         if (cal_finish) begin
            offset_out       <= cal_sum[WIDTH+CAL_LOG2-1:CAL_LOG2];
            offset_valid_out <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_audio_front_end.sv
// Bench for audio_front_end (WIDTH=16, CAL_LOG2=2, DECIM_LOG2=1): table vectors
// for the offset stage, hand sequences for calibration, and a decimator scoreboard.
module tb_audio_front_end;
   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sample_valid_in = 1'b0;
   logic [W-1:0]  sample_in = '0;
   logic          cal_start = 1'b0;
   logic [1:0]    mode = 2'd0;
   logic          calibrating_out, offset_valid_out, sample_valid_out;
   logic [W-1:0]  offset_out, dc_blocked_out, sample_out;

   audio_front_end #(.WIDTH(W), .CAL_LOG2(2), .DECIM_LOG2(1), .FIXED_OFFSET(-2000)) dut (
      .audio_clk        (clk),
      .rst_in_n         (rst_n),
      .sample_valid_in  (sample_valid_in),
      .sample_in        (sample_in),
      .cal_start_in     (cal_start),
      .offset_mode_in   (mode),
      .calibrating_out  (calibrating_out),
      .offset_valid_out (offset_valid_out),
      .offset_out       (offset_out),
      .dc_blocked_out   (dc_blocked_out),
      .sample_valid_out (sample_valid_out),
      .sample_out       (sample_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct { int value; int due; } exp_t;
   exp_t sbq[$];
   int   sb_acc   = 0;
   int   sb_phase = 0;

   typedef struct { logic [1:0] mode; int sample; int exp_dc; } vec_t;
   vec_t tbl [8];

   task automatic cmp(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Decimator model: group of two corrected samples, floor of the mean.
   task automatic sb_push(input int exp_dc);
      exp_t e;
      sb_acc += exp_dc;
      if (sb_phase == 1) begin
         e.value = sb_acc >>> 1;
         e.due   = cyc + 3;
         sbq.push_back(e);
         sb_acc   = 0;
         sb_phase = 0;
      end else begin
         sb_phase = 1;
      end
   endtask

   task automatic send(input int s, input logic [1:0] m, input int exp_dc, input string name);
      mode            = m;
      sample_in       = s[W-1:0];
      sample_valid_in = 1'b1;
      sb_push(exp_dc);
      tick();
      sample_valid_in = 1'b0;
      tick();
      cmp(name, $signed(dc_blocked_out), exp_dc);
   endtask

   task automatic pulse_cal();
      cal_start = 1'b1;
      tick();
      cal_start = 1'b0;
   endtask

   // Output monitor: every strobe must match the head of the queue, on time.
   exp_t mon_e;
   always @(negedge clk) begin
      if (rst_n && sample_valid_out) begin
         n_cmp++;
         if (sbq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_strobe: got sample_out=%0d expected no strobe", $signed(sample_out));
         end else begin
            mon_e = sbq.pop_front();
            if ($signed(sample_out) != mon_e.value || cyc != mon_e.due) begin
               n_bad++;
               $display("FAIL sample_out: got %0d at cycle %0d expected %0d at cycle %0d",
                        $signed(sample_out), cyc, mon_e.value, mon_e.due);
            end else begin
               $display("ok   sample_out: %0d at cycle %0d", mon_e.value, cyc);
            end
         end
      end
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
         mon_e = sbq.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL missing_strobe: got none expected %0d at cycle %0d", mon_e.value, mon_e.due);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0] = '{2'd3, 0,      2000};
      tbl[1] = '{2'd1, 32767,  32767};
      tbl[2] = '{2'd1, -2000,  0};
      tbl[3] = '{2'd0, -32768, -32768};
      tbl[4] = '{2'd2, 5,      5};
      tbl[5] = '{2'd1, -32768, -30768};
      tbl[6] = '{2'd0, 1234,   1234};
      tbl[7] = '{2'd3, -32768, -30768};

      // Reset state
      repeat (3) tick();
      cmp("rst_calibrating", calibrating_out, 0);
      cmp("rst_offset_valid", offset_valid_out, 0);
      cmp("rst_offset", offset_out, 0);
      cmp("rst_dc", dc_blocked_out, 0);
      cmp("rst_valid_out", sample_valid_out, 0);
      cmp("rst_sample_out", sample_out, 0);
      rst_n = 1'b1;
      tick();

      // Offset modes and saturation
      for (int i = 0; i < 8; i++)
         send(tbl[i].sample, tbl[i].mode, tbl[i].exp_dc, $sformatf("vec%0d_dc", i));

      // First calibration, mode 2 (no offset yet -> raw passes through)
      pulse_cal();
      cmp("cal_enter", calibrating_out, 1);
      send(-3, 2'd2, -3, "cal_s0");
      send(-2, 2'd2, -2, "cal_s1");
      send(-2, 2'd2, -2, "cal_s2");
      cmp("cal_busy_before_last", calibrating_out, 1);
      send(-2, 2'd2, -2, "cal_s3");
      cmp("cal_offset", $signed(offset_out), -3);
      cmp("cal_offset_valid", offset_valid_out, 1);
      cmp("cal_done", calibrating_out, 0);
      send(100, 2'd2, 103, "mode2_dc");
      send(-32768, 2'd2, -32765, "mode2_neg_dc");

      // Recalibration: old offset stays in force until replaced
      pulse_cal();
      for (int i = 0; i < 4; i++) begin
         cmp($sformatf("recal_hold_offset%0d", i), $signed(offset_out), -3);
         cmp($sformatf("recal_hold_valid%0d", i), offset_valid_out, 1);
         send(8, 2'd2, 11, $sformatf("recal_s%0d", i));
      end
      cmp("recal_offset", $signed(offset_out), 8);
      send(-32768, 2'd2, -32768, "neg_sat_dc");
      send(0, 2'd3, -8, "mode3_cal_dc");

      // Asynchronous reset mid-group
      send(7, 2'd0, 7, "pre_reset_dc");
      repeat (2) tick();
      #2;
      rst_n = 1'b0;
      #1;
      cmp("async_offset_valid", offset_valid_out, 0);
      cmp("async_offset", offset_out, 0);
      cmp("async_dc", dc_blocked_out, 0);
      cmp("async_sample_out", sample_out, 0);
      cmp("async_calibrating", calibrating_out, 0);
      sb_acc   = 0;
      sb_phase = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      send(0, 2'd3, 2000, "mode3_fixed_dc0");
      send(100, 2'd3, 2100, "mode3_fixed_dc1");

      // Restart in the middle of a calibration
      pulse_cal();
      send(50, 2'd0, 50, "restart_pre0");
      send(50, 2'd0, 50, "restart_pre1");
      pulse_cal();
      send(20, 2'd0, 20, "restart_s0");
      send(20, 2'd0, 20, "restart_s1");
      send(20, 2'd0, 20, "restart_s2");
      cmp("restart_busy", calibrating_out, 1);
      send(20, 2'd0, 20, "restart_s3");
      cmp("restart_offset", $signed(offset_out), 20);
      cmp("restart_done", calibrating_out, 0);

      // Back-to-back decimation burst
      mode = 2'd0;
      begin
         int burst [4];
         burst = '{10, 21, -1, -2};
         for (int i = 0; i < 4; i++) begin
            sample_in       = burst[i][W-1:0];
            sample_valid_in = 1'b1;
            sb_push(burst[i]);
            tick();
         end
      end
      sample_valid_in = 1'b0;
      repeat (8) tick();
      cmp("scoreboard_drained", sbq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
